// File: rtl/iddmm_prod_acc_if.sv
// Product-beat stream in, result-word stream out, for the IDDMM column accumulator.
// The master side feeds products and consumes words; the slave side is the accumulator.
interface iddmm_prod_acc_if #(
    parameter int WORD_W = 128
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*WORD_W-1:0]   in_prod;
    logic                  in_shift;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_W-1:0]     out_word;
    logic                  out_last;
    logic                  out_ovf;

    modport master (
        output in_valid, in_prod, in_shift, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_last, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_shift, in_last, out_ready,
        output in_ready, out_valid, out_word, out_last, out_ovf
    );
endinterface

// File: rtl/iddmm_prod_acc.sv
// Column accumulator behind the IDDMM word multipliers: sums partial products,
// emits the low word on each column close and drains the remaining carry words.
module iddmm_prod_acc #(
    parameter int WORD_W  = 128,
    parameter int GUARD_W = 8
) (
    input logic            clk,
    input logic            rst,
    iddmm_prod_acc_if.slave bus
);
    localparam int ACC_W = 2*WORD_W + GUARD_W;

    typedef enum logic [1:0] {
        ACC,
        DRAIN_LO,
        DRAIN_HI
    } state_t;

    state_t              state;
    logic [ACC_W-1:0]    acc;
    logic                ovf;
    logic                out_valid;
    logic                out_last;
    logic                out_ovf;
    logic [WORD_W-1:0]   out_word;

    logic                free;
    logic                take;
    logic [ACC_W:0]      sum;
    logic [ACC_W-1:0]    sum_t;

    // Output register can take a new word if empty or emptying this edge.
    assign free         = !out_valid || bus.out_ready;
    assign bus.in_ready = (state == ACC) && free;
    assign take         = bus.in_valid && bus.in_ready;

    assign sum   = {1'b0, acc} + {{(GUARD_W+1){1'b0}}, bus.in_prod};
    assign sum_t = sum[ACC_W-1:0];

    assign bus.out_valid = out_valid;
    assign bus.out_word  = out_word;
    assign bus.out_last  = out_last;
    assign bus.out_ovf   = out_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_last  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_ovf   <= 1'b0;
            end
            unique case (state)
                ACC: begin
                    if (take) begin
                        ovf <= ovf | sum[ACC_W];
                        if (bus.in_shift || bus.in_last) begin
                            out_word  <= sum_t[WORD_W-1:0];
                            out_valid <= 1'b1;
                            acc       <= sum_t >> WORD_W;
                        end else begin
                            acc <= sum_t;
                        end
                        if (bus.in_last)
                            state <= DRAIN_LO;
                    end
                end
                DRAIN_LO: begin
                    if (free) begin
                        out_word  <= acc[WORD_W-1:0];
                        out_valid <= 1'b1;
                        state     <= DRAIN_HI;
                    end
                end
                DRAIN_HI: begin
                    // Only guard bits can be nonzero above the low word here.
                    if (free) begin
                        out_word  <= WORD_W'(acc[ACC_W-1:WORD_W]);
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        out_ovf   <= ovf;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_iddmm_prod_acc.sv
// Scoreboard bench for iddmm_prod_acc: directed beats with hand-computed words,
// a monitor pops expected words on every output handshake.
module tb_iddmm_prod_acc;
    localparam int W = 128;

    typedef struct packed {
        logic [W-1:0] word;
        logic         last;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    exp_t q[$];

    iddmm_prod_acc_if #(.WORD_W(W)) bus();

    iddmm_prod_acc #(.WORD_W(W), .GUARD_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] w, input logic l, input logic o);
        exp_t e;
        e.word = w;
        e.last = l;
        e.ovf  = o;
        q.push_back(e);
    endtask

    // Present one beat and hold it until it is accepted.
    task automatic send(input logic [2*W-1:0] p, input logic s, input logic l);
        bit ok;
        int k;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 200) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_prod  = p;
            bus.in_shift = s;
            bus.in_last  = l;
            #1;
            ok = bus.in_ready;
            @(posedge clk);
            k++;
        end
        #1;
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 600) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d words left expected 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [2*W-1:0] mul(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] x;
        logic [2*W-1:0] y;
        x = {{W{1'b0}}, a};
        y = {{W{1'b0}}, b};
        return x * y;
    endfunction

    function automatic logic [W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: every output handshake must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none",
                             bus.out_word);
                end else begin
                    e = q.pop_front();
                    chk("word", {{W{1'b0}}, bus.out_word}, {{W{1'b0}}, e.word});
                    chk("last", {255'd0, bus.out_last}, {255'd0, e.last});
                    if (e.last)
                        chk("ovf", {255'd0, bus.out_ovf}, {255'd0, e.ovf});
                end
            end
        end
    end

    logic [W-1:0]     ones;
    logic [2*W-1:0]   full;
    logic [W-1:0]     a0, a1, b0, b1;
    logic [4*W-1:0]   p;

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        ones         = {W{1'b1}};
        full         = {(2*W){1'b1}};
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_prod  = '0;
        bus.in_shift = 1'b0;
        bus.in_last  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", {255'd0, bus.out_valid}, 256'd0);
        chk("rst_in_ready", {255'd0, bus.in_ready}, 256'd1);
        chk("rst_out_word", {{W{1'b0}}, bus.out_word}, 256'd0);
        chk("rst_out_last", {255'd0, bus.out_last}, 256'd0);
        chk("rst_out_ovf", {255'd0, bus.out_ovf}, 256'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single beat: 2^128+5 -> 5, 1, 0 on consecutive cycles.
        push(128'd5, 1'b0, 1'b0);
        push(128'd1, 1'b0, 1'b0);
        push(128'd0, 1'b1, 1'b0);
        send((256'd1 << 128) + 256'd5, 1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("t1_valid_run", {255'd0, bus.out_valid}, 256'd1);
        end
        @(negedge clk);
        #1;
        chk("t1_valid_drop", {255'd0, bus.out_valid}, 256'd0);
        wait_drain();

        // Carry across words.
        push({ones[W-1:1], 1'b0}, 1'b0, 1'b0);
        push(ones, 1'b0, 1'b0);
        push(128'd1, 1'b1, 1'b0);
        send(full, 1'b0, 1'b0);
        send(full, 1'b0, 1'b1);
        wait_drain();

        // 2x2-word column stream.
        for (int it = 0; it < 3; it++) begin
            a0 = rnd128();
            a1 = rnd128();
            b0 = rnd128();
            b1 = rnd128();
            if (it == 0) begin
                a0 = ones;
                a1 = ones;
                b0 = ones;
                b1 = ones;
            end
            p = {{(2*W){1'b0}}, a1, a0} * {{(2*W){1'b0}}, b1, b0};
            push(p[W-1:0], 1'b0, 1'b0);
            push(p[2*W-1:W], 1'b0, 1'b0);
            push(p[3*W-1:2*W], 1'b0, 1'b0);
            push(p[4*W-1:3*W], 1'b0, 1'b0);
            push(128'd0, 1'b1, 1'b0);
            send(mul(a0, b0), 1'b1, 1'b0);
            send(mul(a0, b1), 1'b0, 1'b0);
            send(mul(a1, b0), 1'b1, 1'b0);
            send(mul(a1, b1), 1'b0, 1'b1);
            wait_drain();
        end

        // Backpressure: word 3 held while beat 9 waits.
        @(negedge clk);
        bus.out_ready = 1'b0;
        push(128'd3, 1'b0, 1'b0);
        push(128'd9, 1'b0, 1'b0);
        push(128'd0, 1'b0, 1'b0);
        push(128'd0, 1'b1, 1'b0);
        send(256'd3, 1'b1, 1'b0);
        fork
            send(256'd9, 1'b0, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    chk("bp_in_ready", {255'd0, bus.in_ready}, 256'd0);
                    chk("bp_valid", {255'd0, bus.out_valid}, 256'd1);
                    chk("bp_word", {{W{1'b0}}, bus.out_word}, 256'd3);
                    chk("bp_last", {255'd0, bus.out_last}, 256'd0);
                end
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();

        // 256 full-scale beats: no overflow.
        push({{(W-8){1'b1}}, 8'h00}, 1'b0, 1'b0);
        push(ones, 1'b0, 1'b0);
        push(128'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++)
            send(full, 1'b0, i == 255);
        wait_drain();

        // 257 beats: sticky overflow on the last word.
        push(~128'h100, 1'b0, 1'b0);
        push(ones, 1'b0, 1'b0);
        push(128'd0, 1'b1, 1'b1);
        for (int i = 0; i < 257; i++)
            send(full, 1'b0, i == 256);
        wait_drain();

        // Following transaction starts clean.
        push(128'd5, 1'b0, 1'b0);
        push(128'd1, 1'b0, 1'b0);
        push(128'd0, 1'b1, 1'b0);
        send((256'd1 << 128) + 256'd5, 1'b1, 1'b1);
        wait_drain();

        // Reset while in DRAIN_LO with a word pending.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(256'd5, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("pre_rst_valid", {255'd0, bus.out_valid}, 256'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {255'd0, bus.out_valid}, 256'd0);
        chk("async_rst_ready", {255'd0, bus.in_ready}, 256'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        push(128'd7, 1'b0, 1'b0);
        push(128'd0, 1'b0, 1'b0);
        push(128'd0, 1'b1, 1'b0);
        send(256'd7, 1'b0, 1'b1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
